// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared branch predictor constants and counter encodings
package branch_predictor_pkg;

    localparam int BHT_ADDR_DEF = 8;
    localparam int HIST_LEN_DEF = 8;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit saturating increment/decrement
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr,
    input  logic dir,
    output ctr_e ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (dir) begin
            if (ctr != ST) ctr_next = ctr_e'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) ctr_next = ctr_e'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit counter direction predictor trained by committed branches
// Optional gshare indexing with BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BHT_ADDR = BHT_ADDR_DEF,
    parameter int HIST_LEN = HIST_LEN_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] if_pc,
    output logic        if_pred_jump,
    input  logic        rob_valid,
    input  logic [31:0] now_pc,
    input  logic        should_jump,
    input  logic        clear
);

    localparam int ENTRIES = 1 << BHT_ADDR;

    ctr_e bht_q [ENTRIES];
    ctr_e bht_d [ENTRIES];
    ctr_e upd_ctr;
    logic [BHT_ADDR-1:0] q_idx;
    logic [BHT_ADDR-1:0] u_idx;
    logic upd_en;

    assign upd_en = rdy_in && rob_valid;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [HIST_LEN-1:0] ghr_q, ghr_d;

    assign q_idx = if_pc[BHT_ADDR+1:2] ^ BHT_ADDR'(ghr_q);
    assign u_idx = now_pc[BHT_ADDR+1:2] ^ BHT_ADDR'(ghr_q);

    always_comb begin
        ghr_d = ghr_q;
        if (upd_en) ghr_d = {ghr_q[HIST_LEN-2:0], should_jump};
    end
`else
    logic [HIST_LEN-1:0] hist_unused;

    assign hist_unused = '0;
    assign q_idx = if_pc[BHT_ADDR+1:2];
    assign u_idx = now_pc[BHT_ADDR+1:2];
`endif

    // Flush has no effect: only committed outcomes ever reach the table.
    logic inputs_unused;
    assign inputs_unused = ^{if_pc[31:BHT_ADDR+2], if_pc[1:0],
                             now_pc[31:BHT_ADDR+2], now_pc[1:0], clear};

    assign if_pred_jump = bht_q[q_idx][1];

    sat_counter2 u_sat (
        .ctr      (bht_q[u_idx]),
        .dir      (should_jump),
        .ctr_next (upd_ctr)
    );

    always_comb begin
        bht_d = bht_q;
        if (upd_en) bht_d[u_idx] = upd_ctr;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= WNT;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            ghr_q <= '0;
`endif
        end else begin
            bht_q <= bht_d;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            ghr_q <= ghr_d;
`endif
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [31:0] if_pc = '0;
    logic        if_pred_jump;
    logic        rob_valid = 1'b0;
    logic [31:0] now_pc = '0;
    logic        should_jump = 1'b0;
    logic        clear = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    int m_bht [256];
    int m_ghr = 0;

    logic  exp_q [$];
    string tag_q [$];

    branch_predictor dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .if_pc        (if_pc),
        .if_pred_jump (if_pred_jump),
        .rob_valid    (rob_valid),
        .now_pc       (now_pc),
        .should_jump  (should_jump),
        .clear        (clear)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    function automatic int midx(input logic [31:0] pc);
        int ix;
        ix = int'(pc[9:2]);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        ix = ix ^ m_ghr;
`endif
        return ix;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_bht[i] = 1;
        m_ghr = 0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic dir);
        int e;
        e = midx(pc);
        if (dir) m_bht[e] = (m_bht[e] == 3) ? 3 : m_bht[e] + 1;
        else     m_bht[e] = (m_bht[e] == 0) ? 0 : m_bht[e] - 1;
        m_ghr = ((m_ghr << 1) | int'(dir)) & 8'hFF;
    endtask

    // Expected value is queued when the query is driven and popped on sampling.
    task automatic query(input logic [31:0] pc, input string tag);
        int v;
        logic got;
        if_pc = pc;
        v = m_bht[midx(pc)];
        exp_q.push_back(v[1]);
        tag_q.push_back(tag);
        #2;
        got = if_pred_jump;
        check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    task automatic update(input logic [31:0] pc, input logic dir);
        rob_valid = 1'b1;
        now_pc = pc;
        should_jump = dir;
        @(posedge clk_in);
        if (rdy_in) model_update(pc, dir);
        #1;
        rob_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        model_reset();
        #1 rst_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    logic [31:0] pcs [5];

    initial begin
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h500;
        pcs[3] = 32'h200; pcs[4] = 32'h3FC;
        model_reset();

        pulse_reset();
        query(32'h0000_0000, "reset_pc0");
        query(32'h0000_0104, "reset_pc104");
        query(32'hFFFF_FFFC, "reset_pcmax");

        query(32'h100, "train_before");
        update(32'h100, 1'b1);
        query(32'h100, "train_after1");
        update(32'h100, 1'b1);
        query(32'h100, "train_after2");
        update(32'h100, 1'b1);
        update(32'h100, 1'b0);
        query(32'h100, "sat_hi_nt1");
        update(32'h100, 1'b0);
        query(32'h100, "sat_hi_nt2");

        update(32'h200, 1'b0);
        update(32'h200, 1'b0);
        update(32'h200, 1'b0);
        update(32'h200, 1'b1);
        query(32'h200, "sat_lo");

        pulse_reset();
        update(32'h100, 1'b1);
        update(32'h100, 1'b1);
        query(32'h500, "alias_500");
        query(32'h104, "index_104");
        query(32'h100, "alias_base");

        rdy_in = 1'b0;
        rob_valid = 1'b1;
        now_pc = 32'h300;
        should_jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            #1;
            query(32'h300, "stall_hold");
        end
        rdy_in = 1'b1;
        clear = 1'b1;
        update(32'h300, 1'b1);
        query(32'h300, "flush_update");
        query(32'h100, "flush_intact");

        rob_valid = 1'b1;
        now_pc = 32'h104;
        should_jump = 1'b1;
        @(negedge clk_in);
        #3 rst_in = 1'b0;
        model_reset();
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        rob_valid = 1'b0;
        query(32'h104, "reset_mid_update");
        query(32'h100, "reset_clears");

`ifdef BRANCH_PREDICTOR_GSHARE_EN
        for (int i = 0; i < 4; i++) update(32'h100, 1'b1);
        query(32'h100, "gshare_q_4f");
        update(32'h100, 1'b1);
        query(32'h140, "gshare_e4f_trained");
        query(32'h17C, "gshare_e40");
        query(32'h100, "gshare_q_5f");
`endif

        for (int i = 0; i < 60; i++) begin
            rdy_in = ($urandom_range(0, 4) != 0);
            clear = ($urandom_range(0, 3) == 0);
            update(pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));
            rdy_in = 1'b1;
            query(pcs[$urandom_range(0, 4)], "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
